// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV M-extension multiply/divide unit beside the EX-stage ALU.
//   One operation at a time: radix-2 shift-add multiply or restoring divide,
//   XLEN iterations, then the result is held under a valid/ready handshake
//   toward MEM. EX stalls the pipe while o_busy is high.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready     operation request from EX; o_ready high only in IDLE
//   i_func3               000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                         100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_r_data1, i_r_data2  rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   i_rd_tag              destination tag, returned unmodified on o_rd_tag
//   i_flush               squash whatever is in flight, back to IDLE
//   o_valid / i_ready     result handshake toward MEM
//   o_result, o_rd_tag    registered result and its tag
//   o_busy                high in CALC or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; o_ready high
// CALC  | one shift-add / restoring-divide iteration per edge, XLEN edges
// DONE  | o_valid high, result/tag held until i_ready
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_func3,
  input  logic [XLEN-1:0]  i_r_data1,
  input  logic [XLEN-1:0]  i_r_data2,
  input  logic [TAG_W-1:0] i_rd_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched operation context
  logic [2:0]        func3_q;
  logic              sign_q;
  logic [XLEN-1:0]   oper_q;     // multiplicand for MUL*, divisor for DIV*
  logic [XLEN-1:0]   acc_hi_q;   // product high half / partial remainder
  logic [XLEN-1:0]   acc_lo_q;   // multiplier -> product low half / dividend -> quotient
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic [TAG_W-1:0]  tag_q;

  // ------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ------------------------------------------------------------------
  logic            accept;
  logic            rs1_signed, rs2_signed;
  logic            sign1, sign2;
  logic [XLEN-1:0] mag1, mag2;
  logic            req_is_div, req_is_rem;
  logic            req_div0, req_ovf, req_special, req_sign;
  logic [XLEN-1:0] special_result;

  assign accept = (state_q == ST_IDLE) && i_valid && !i_flush;

  assign rs1_signed = (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
                      (i_func3 == 3'b100) || (i_func3 == 3'b110);
  assign rs2_signed = (i_func3 == 3'b001) || (i_func3 == 3'b100) ||
                      (i_func3 == 3'b110);

  assign sign1 = rs1_signed && i_r_data1[XLEN-1];
  assign sign2 = rs2_signed && i_r_data2[XLEN-1];

  // Magnitude of the most negative value is its own bit pattern, which is
  // exactly the unsigned magnitude wanted, so no extra bit is required.
  assign mag1 = sign1 ? -i_r_data1 : i_r_data1;
  assign mag2 = sign2 ? -i_r_data2 : i_r_data2;

  assign req_is_div = i_func3[2];
  assign req_is_rem = i_func3[1];

  // Remainder takes the dividend's sign; everything else the product of signs.
  assign req_sign = (req_is_div && req_is_rem) ? sign1 : (sign1 ^ sign2);

  assign req_div0    = req_is_div && (i_r_data2 == '0);
  assign req_ovf     = req_is_div && !i_func3[0] &&
                       (i_r_data1 == MIN_NEG) && (i_r_data2 == '1);
  assign req_special = req_div0 || req_ovf;

  always_comb begin
    special_result = '0;
    if (req_div0) begin
      special_result = req_is_rem ? i_r_data1 : '1;
    end else begin
      special_result = req_is_rem ? '0 : i_r_data1;
    end
  end

  // ------------------------------------------------------------------
  // One datapath iteration
  // ------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   hi_nx, lo_nx;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, oper_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, oper_q};
    div_ge    = (div_shift >= {1'b0, oper_q});
    hi_nx     = acc_hi_q;
    lo_nx     = acc_lo_q;
    if (func3_q[2]) begin
      // Restoring divide: shift in the next dividend bit, subtract if it fits.
      hi_nx = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_nx = {acc_lo_q[XLEN-2:0], div_ge};
    end else begin
      // Shift-add: the carry out of the add becomes the new top bit.
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  // Final result is formed from the post-iteration value so it can be
  // registered on the same edge that moves CALC to DONE.
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   calc_result;

  always_comb begin
    prod_raw = {hi_nx, lo_nx};
    prod_fix = sign_q ? -prod_raw : prod_raw;
    quo_fix  = sign_q ? -lo_nx : lo_nx;
    rem_fix  = sign_q ? -hi_nx : hi_nx;
    calc_result = '0;
    if (func3_q[2]) begin
      calc_result = func3_q[1] ? rem_fix : quo_fix;
    end else if (func3_q[1:0] == 2'b00) begin
      calc_result = prod_fix[XLEN-1:0];
    end else begin
      calc_result = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = req_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides every other transition, including a DONE drain.
    if (i_flush) begin
      state_d = ST_IDLE;
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      func3_q  <= '0;
      sign_q   <= 1'b0;
      oper_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (accept) begin
      func3_q  <= i_func3;
      sign_q   <= req_sign;
      oper_q   <= req_is_div ? mag2 : mag1;
      acc_hi_q <= '0;
      acc_lo_q <= req_is_div ? mag1 : mag2;
      cnt_q    <= '0;
      tag_q    <= i_rd_tag;
      if (req_special) begin
        result_q <= special_result;
      end
    end else if ((state_q == ST_CALC) && !i_flush) begin
      acc_hi_q <= hi_nx;
      acc_lo_q <= lo_nx;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_ITER) begin
        result_q <= calc_result;
      end
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_result = result_q;
  assign o_rd_tag = tag_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_func3;
  logic [XLEN-1:0]  i_r_data1;
  logic [XLEN-1:0]  i_r_data2;
  logic [TAG_W-1:0] i_rd_tag;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_result;
  logic [TAG_W-1:0] o_rd_tag;
  logic             o_busy;

  // 16-bit instance
  logic             v16, rdy16, flush16, ordy16, ov16, busy16;
  logic [2:0]       f16;
  logic [15:0]      a16, b16, res16;
  logic [TAG_W-1:0] t16, otag16;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [TAG_W+XLEN-1:0] sb_q[$];

  ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_func3   (i_func3),
    .i_r_data1 (i_r_data1),
    .i_r_data2 (i_r_data2),
    .i_rd_tag  (i_rd_tag),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_rd_tag  (o_rd_tag),
    .o_busy    (o_busy)
  );

  ex_muldiv_unit #(.XLEN(16), .TAG_W(TAG_W)) dut16 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (v16),
    .o_ready   (ordy16),
    .i_func3   (f16),
    .i_r_data1 (a16),
    .i_r_data2 (b16),
    .i_rd_tag  (t16),
    .i_flush   (flush16),
    .o_valid   (ov16),
    .i_ready   (rdy16),
    .o_result  (res16),
    .o_rd_tag  (otag16),
    .o_busy    (busy16)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    r  = '0;
    case (f)
      3'b000: begin p = ua * ub; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: begin if (b == 32'h0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
      3'b101: begin if (b == 32'h0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end end
      3'b110: begin if (b == 32'h0) r = a; else begin p = sa % sb; r = p[31:0]; end end
      default: begin if (b == 32'h0) r = a; else begin p = ua % ub; r = p[31:0]; end end
    endcase
    return r;
  endfunction

  // Drive one op, wait for its result, compare against the scoreboard head,
  // optionally hold i_ready low for a while, then drain.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    logic ready_low_ok;
    logic stable_ok;
    logic [TAG_W+XLEN-1:0] item;
    sb_q.push_back({t, exp});
    i_func3   = f;
    i_r_data1 = a;
    i_r_data2 = b;
    i_rd_tag  = t;
    i_valid   = 1'b1;
    @(posedge i_clk); #1;
    // Garbage on the request inputs after acceptance must not matter.
    i_valid   = 1'b0;
    i_func3   = 3'($urandom);
    i_r_data1 = $urandom;
    i_r_data2 = $urandom;
    i_rd_tag  = TAG_W'($urandom);
    lat = 0;
    ready_low_ok = 1'b1;
    while (!o_valid && lat < 100) begin
      if (o_ready !== 1'b0 || o_busy !== 1'b1) ready_low_ok = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
    check({name, " valid"}, o_valid, 1'b1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " ready_low_in_calc"}, ready_low_ok, 1'b1);
    check({name, " ready_low_in_done"}, o_ready, 1'b0);
    if (sb_q.size() > 0) item = sb_q.pop_front();
    else item = 'x;
    check({name, " result"}, o_result, item[XLEN-1:0]);
    check({name, " tag"}, o_rd_tag, item[TAG_W+XLEN-1:XLEN]);
    if (hold > 0) begin
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge i_clk); #1;
        if (o_valid !== 1'b1 || o_result !== item[XLEN-1:0] || o_rd_tag !== item[TAG_W+XLEN-1:XLEN])
          stable_ok = 1'b0;
      end
      check({name, " held_stable"}, stable_ok, 1'b1);
    end
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check({name, " drained_valid"}, o_valid, 1'b0);
    check({name, " drained_ready"}, o_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic never_valid;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int rlat;

    i_rst_n = 1'b0; i_valid = 1'b0; i_func3 = 3'b000; i_r_data1 = '0; i_r_data2 = '0;
    i_rd_tag = '0; i_flush = 1'b0; i_ready = 1'b0;
    v16 = 1'b0; rdy16 = 1'b0; flush16 = 1'b0; f16 = 3'b000; a16 = '0; b16 = '0; t16 = '0;

    // Reset state, with a request presented while reset is held.
    #2;
    i_valid = 1'b1; i_r_data1 = 32'd3; i_r_data2 = 32'd4; i_rd_tag = 5'd9;
    @(posedge i_clk); #1;
    check("reset valid",  o_valid,  1'b0);
    check("reset busy",   o_busy,   1'b0);
    check("reset ready",  o_ready,  1'b1);
    check("reset result", o_result, 32'h0);
    check("reset tag",    o_rd_tag, 5'h0);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Main function
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32, 0);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 32, 0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 32, 0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 32, 0);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 32, 0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 32, 0);
    run_op("divu",   3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 32, 0);
    run_op("remu",   3'b111, 32'd100, 32'd7, 5'd13, 32'd2,  32, 0);

    // Special cases: DONE on the accepting edge itself
    run_op("div0",   3'b100, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 0, 0);
    run_op("rem0",   3'b110, 32'd5, 32'd0, 5'd15, 32'd5, 0, 0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 0, 0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 0, 0);

    // Backpressure: hold i_ready low for 5 cycles in DONE
    run_op("hold", 3'b000, 32'd1234, 32'd5678, 5'd18, 32'd7006652, 32, 5);

    // Flush at iteration 10
    i_func3 = 3'b000; i_r_data1 = 32'd3; i_r_data2 = 32'd3; i_rd_tag = 5'd19; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge i_clk); #1; end
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_calc ready", o_ready, 1'b1);
    check("flush_calc busy",  o_busy,  1'b0);
    never_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_valid !== 1'b0) never_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    check("flush_calc never_valid", never_valid, 1'b1);

    // Flush together with a request in IDLE: request dropped
    i_func3 = 3'b101; i_r_data1 = 32'd9; i_r_data2 = 32'd0; i_rd_tag = 5'd20;
    i_valid = 1'b1; i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_idle busy",  o_busy,  1'b0);
    check("flush_idle ready", o_ready, 1'b1);
    never_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_valid !== 1'b0) never_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    check("flush_idle never_valid", never_valid, 1'b1);

    // Asynchronous reset mid-CALC, between clock edges
    i_func3 = 3'b001; i_r_data1 = 32'h1234_5678; i_r_data2 = 32'h9ABC_DEF0; i_rd_tag = 5'd21;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge i_clk); #1; end
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_rst busy",   o_busy,   1'b0);
    check("async_rst valid",  o_valid,  1'b0);
    check("async_rst ready",  o_ready,  1'b1);
    check("async_rst result", o_result, 32'h0);
    check("async_rst tag",    o_rd_tag, 5'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_op("after_rst", 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd22, 32'hFFFF_FFFF, 32, 0);

    // Randomised operations against the reference model
    for (int k = 0; k < 10; k++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (k == 4) rb = 32'h0;
      if (k == 7) begin rf = 3'b110; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      rlat = (rf[2] && (rb == 32'h0 ||
              (!rf[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) ? 0 : 32;
      run_op($sformatf("rand%0d_f%0d", k, rf), rf, ra, rb, TAG_W'(k + 1),
             ref_op(rf, ra, rb), rlat, 0);
    end

    // XLEN = 16 instance
    f16 = 3'b000; a16 = 16'h00FF; b16 = 16'h00FF; t16 = 5'h1A; v16 = 1'b1;
    @(posedge i_clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    check("x16 latency", lat, 16);
    check("x16 result",  res16,  16'hFE01);
    check("x16 tag",     otag16, 5'h1A);
    rdy16 = 1'b1;
    @(posedge i_clk); #1;
    rdy16 = 1'b0;
    check("x16 drained", ordy16, 1'b1);

    check("scoreboard empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
